// File: rtl/iob_cpu_bus_bridge.sv
// CPU valid/ready cmd/rsp port to IOb native bus bridge.
// Tracks up to MAX_OUT outstanding transactions so that responses return in order.
module iob_cpu_bus_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 4,
  parameter int BOOT_REMAP = 1
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  input  logic                  boot_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [DATA_W-1:0]     cmd_data_i,
  input  logic [DATA_W/8-1:0]   cmd_mask_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  rsp_error_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  output logic                  proto_err_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

  logic [MAX_OUT-1:0] r_is_wr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_proto_err;

  logic w_full, w_empty, w_accept, w_head_wr;
  logic w_pop, w_rd_pop, w_bypass, w_push, w_proto;
  logic w_addr_msb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_head_wr = r_is_wr[r_rd_ptr];

  assign iob_avalid_o = cmd_valid_i & ~w_full;
  assign cmd_ready_o  = iob_ready_i & ~w_full;
  assign w_accept     = cmd_valid_i & cmd_ready_o;

  assign w_addr_msb  = (BOOT_REMAP != 0) ? ~boot_i : cmd_addr_i[ADDR_W-1];
  assign iob_addr_o  = {w_addr_msb, cmd_addr_i[ADDR_W-2:0]};
  assign iob_wdata_o = cmd_data_i;
  assign iob_wstrb_o = cmd_wr_i ? cmd_mask_i : '0;

  // A write head retires on its own; a read head waits for its data.
  assign w_pop    = ~w_empty & (w_head_wr | iob_rvalid_i);
  assign w_rd_pop = ~w_empty & ~w_head_wr & iob_rvalid_i;
  // Writes into an idle bridge are acked directly without occupying a slot.
  assign w_bypass = w_accept & cmd_wr_i & w_empty;
  assign w_push   = w_accept & ~w_bypass;
  assign w_proto  = iob_rvalid_i & (w_empty | w_head_wr);

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_error_o = 1'b0;
  assign proto_err_o = r_proto_err;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_is_wr     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_proto_err <= 1'b0;
    end else if (cke_i) begin
      r_rsp_valid <= w_pop | w_bypass;
      if (w_rd_pop) r_rsp_data <= iob_rdata_i;
      if (w_proto) r_proto_err <= 1'b1;
      if (w_push) begin
        r_is_wr[r_wr_ptr] <= cmd_wr_i;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_cpu_bus_bridge.sv
// Bench for iob_cpu_bus_bridge: directed scenarios plus randomized traffic
// checked against a queue-based model of outstanding transactions.
module tb_iob_cpu_bus_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic          clk_i = 1'b0;
  logic          cke_i, arst_i, boot_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  logic [SW-1:0] cmd_mask_i;
  logic          rsp_valid_o, rsp_error_o;
  logic [DW-1:0] rsp_data_o;
  logic          iob_avalid_o;
  logic [AW-1:0] iob_addr_o;
  logic [DW-1:0] iob_wdata_o;
  logic [SW-1:0] iob_wstrb_o;
  logic          iob_ready_i, iob_rvalid_i;
  logic [DW-1:0] iob_rdata_i;
  logic          proto_err_o;

  iob_cpu_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .BOOT_REMAP(1)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .boot_i(boot_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_mask_i(cmd_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: kinds of accepted-but-unanswered transactions, oldest first (1 = write).
  bit            pend[$];
  logic          exp_rsp;
  logic [DW-1:0] exp_data;
  logic          exp_perr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] m, input logic rdy,
                      input logic rv, input logic [DW-1:0] rd, input logic bt,
                      input logic ck, output bit acc);
    bit full, was_empty;
    @(negedge clk_i);
    cmd_valid_i = v; cmd_wr_i = wr; cmd_addr_i = a; cmd_data_i = d; cmd_mask_i = m;
    iob_ready_i = rdy; iob_rvalid_i = rv; iob_rdata_i = rd; boot_i = bt; cke_i = ck;
    #1;
    full = (pend.size() == MO);
    chk("avalid", iob_avalid_o, v & !full);
    chk("cmd_ready", cmd_ready_o, rdy & !full);
    chk("wstrb", iob_wstrb_o, wr ? m : '0);
    chk("wdata", iob_wdata_o, d);
    chk("addr", iob_addr_o, {~bt, a[AW-2:0]});
    acc = v && rdy && !full;
    if (ck) begin
      was_empty = (pend.size() == 0);
      exp_rsp = 1'b0;
      if (was_empty) begin
        if (rv) exp_perr = 1'b1;
      end else if (pend[0]) begin
        void'(pend.pop_front());
        exp_rsp = 1'b1;
        if (rv) exp_perr = 1'b1;
      end else if (rv) begin
        void'(pend.pop_front());
        exp_rsp = 1'b1;
        exp_data = rd;
      end
      if (acc) begin
        if (was_empty && wr) exp_rsp = 1'b1;
        else pend.push_back(wr);
      end
    end
    @(posedge clk_i);
    #1;
    chk("rsp_valid", rsp_valid_o, exp_rsp);
    chk("rsp_data", rsp_data_o, exp_data);
    chk("proto_err", proto_err_o, exp_perr);
    chk("rsp_error", rsp_error_o, 1'b0);
  endtask

  task automatic idle();
    bit acc;
    step(0, 0, '0, '0, '0, 1, 0, '0, 0, 1, acc);
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a, input logic rv, input logic [DW-1:0] rd);
    bit acc;
    step(1, 0, a, '0, '0, 1, rv, rd, 0, 1, acc);
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (pend.size() > 0 && guard < 50) begin
      step(0, 0, '0, '0, '0, 1, !pend[0], $urandom, 0, 1, acc);
      guard++;
    end
    chk("drain_empty", pend.size(), 0);
  endtask

  initial begin
    bit acc;
    int got;
    int guard;
    logic rv;
    arst_i = 1'b1; cke_i = 1'b1; boot_i = 1'b0;
    cmd_valid_i = 0; cmd_wr_i = 0; cmd_addr_i = '0; cmd_data_i = '0; cmd_mask_i = '0;
    iob_ready_i = 0; iob_rvalid_i = 0; iob_rdata_i = '0;
    exp_rsp = 1'b0; exp_data = '0; exp_perr = 1'b0;
    #12;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_proto_err", proto_err_o, 0);
    chk("rst_count", dut.r_count, 0);
    @(negedge clk_i) arst_i = 1'b0;

    // single write on an empty bridge: direct ack, no slot used
    step(1, 1, 32'h10, 32'hA5A5_0001, 4'hF, 1, 0, '0, 0, 1, acc);
    chk("t1_ack", rsp_valid_o, 1);
    chk("t1_count", dut.r_count, 0);
    idle();

    // read with data three cycles later
    rd_cmd(32'h20, 0, '0);
    idle(); idle();
    rd_cmd(32'h0, 0, '0);  // cmd_valid=1 but that adds a second read
    drain();
    // re-run cleanly with exact timing
    rd_cmd(32'h20, 0, '0);
    idle(); idle();
    step(0, 0, '0, '0, '0, 1, 1, 32'hDEAD_BEEF, 0, 1, acc);
    chk("t2_valid", rsp_valid_o, 1);
    chk("t2_data", rsp_data_o, 32'hDEAD_BEEF);
    idle();

    // read, write, read back to back
    rd_cmd(32'h100, 0, '0);
    step(1, 1, 32'h104, 32'h55, 4'h3, 1, 0, '0, 0, 1, acc);
    rd_cmd(32'h108, 1, 32'h1);
    chk("t3_r1", rsp_data_o, 32'h1);
    idle();
    chk("t3_wack", rsp_valid_o, 1);
    chk("t3_wack_data", rsp_data_o, 32'h1);
    idle();
    chk("t3_gap", rsp_valid_o, 0);
    step(0, 0, '0, '0, '0, 1, 1, 32'h2, 0, 1, acc);
    chk("t3_r2", rsp_data_o, 32'h2);
    idle();

    // fill to MAX_OUT, then pointer wrap under sustained traffic
    for (int i = 0; i < MO; i++) rd_cmd(32'h200 + 4 * i, 0, '0);
    step(1, 0, 32'h300, '0, '0, 1, 0, '0, 0, 1, acc);
    chk("t4_full_ready", cmd_ready_o, 0);
    chk("t4_full_avalid", iob_avalid_o, 0);
    step(1, 0, 32'h300, '0, '0, 1, 1, 32'h77, 0, 1, acc);
    chk("t4_pop_no_acc", acc, 0);
    step(1, 0, 32'h300, '0, '0, 1, 0, '0, 0, 1, acc);
    chk("t4_acc_after_pop", acc, 1);
    got = 0; guard = 0;
    while (got < 20 && guard < 100) begin
      step(1, 0, $urandom, '0, '0, 1, 1, $urandom, 0, 1, acc);
      if (acc) got++;
      guard++;
    end
    chk("t4_wrap_reads", got, 20);
    drain();

    // boot remap
    step(0, 0, 32'h8000_0004, '0, '0, 1, 0, '0, 1, 1, acc);
    chk("t5_boot", iob_addr_o, 32'h0000_0004);
    step(0, 0, 32'h8000_0004, '0, '0, 1, 0, '0, 0, 1, acc);
    chk("t5_run", iob_addr_o, 32'h8000_0004);

    // clock enable low holds state while the request path stays live
    rd_cmd(32'h40, 0, '0);
    step(1, 1, 32'h44, 32'h9, 4'h1, 1, 1, 32'hCAFE, 0, 0, acc);
    drain();

    // stray rvalid then reset with reads pending
    step(0, 0, '0, '0, '0, 1, 1, 32'hBAD, 0, 1, acc);
    chk("t6_perr", proto_err_o, 1);
    chk("t6_no_rsp", rsp_valid_o, 0);
    idle(); idle();
    chk("t6_perr_sticky", proto_err_o, 1);
    rd_cmd(32'h50, 0, '0);
    rd_cmd(32'h54, 0, '0);
    @(negedge clk_i);
    cmd_valid_i = 0; iob_rvalid_i = 0;
    #2 arst_i = 1'b1;
    #1;
    chk("t6_rst_count", dut.r_count, 0);
    chk("t6_rst_rsp", rsp_valid_o, 0);
    chk("t6_rst_perr", proto_err_o, 0);
    chk("t6_rst_data", rsp_data_o, 0);
    pend.delete();
    exp_rsp = 1'b0; exp_data = '0; exp_perr = 1'b0;
    @(negedge clk_i) arst_i = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv = (pend.size() > 0 && !pend[0]) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           SW'($urandom), 1'($urandom_range(0, 3) != 0), rv, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0), acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
